// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants and helpers for the 7-segment scan
//               controller: the all-dark segment byte, the inactive anode
//               level, the display-mode encoding and the hex-to-segment
//               lookup used by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // All segments dark (segments and decimal point are active-low).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Level of a deselected anode line; replicate to DIGITS bits for "all off".
    localparam logic AN_OFF_LVL = 1'b1;

    // Display source selection for a committed frame.
    typedef enum logic [0:0] {
        MODE_RAW = 1'b0,
        MODE_HEX = 1'b1
    } scan_mode_t;

    // Nibble to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decode
// Description : Combinational hex-digit decoder producing the active-low
//               cathode byte {dp,g,f,e,d,c,b,a}.
//   i_nibble  in  4  hex value to display
//   i_dp      in  1  decimal point on (active-high)
//   o_cn      out 8  active-low segment byte
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_cn
);

    assign o_cn = {~i_dp, hex_to_seg(i_nibble)};

endmodule : seg_hex_decode
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed common-anode 7-segment scan controller with
//               prescaled scan, per-digit blanking, PWM brightness,
//               anti-ghost dead time, hex/raw modes and tear-free updates.
//   clk         in   1           system clock, rising edge
//   rst         in   1           synchronous active-high reset
//   update      in   1           strobe: stage all display inputs
//   mode        in   1           1 = hex decode, 0 = raw segment bytes
//   seg_raw     in   8*DIGITS    raw active-low bytes, digit i = [8i+7:8i]
//   hex_val     in   4*DIGITS    nibble per digit, digit i = [4i+3:4i]
//   dp          in   DIGITS      decimal point per digit (hex mode)
//   blank_mask  in   DIGITS      1 = digit kept dark
//   brightness  in   BRIGHT_W    PWM level, used live
//   AN          out  DIGITS      anode select, active-low, registered
//   CN          out  8           {dp,g,f,e,d,c,b,a}, active-low, registered
//   frame_done  out  1           pulse when the digit 0 slot ends
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1000,
    parameter int BRIGHT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  update,
    input  logic                  mode,
    input  logic [8*DIGITS-1:0]   seg_raw,
    input  logic [4*DIGITS-1:0]   hex_val,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            CN,
    output logic                  frame_done
);

    localparam int c_cnt_w = $clog2(SCAN_DIV);
    localparam int c_idx_w = $clog2(DIGITS);
    localparam int c_ot_w  = BRIGHT_W + $clog2(SCAN_DIV) + 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_top  = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_ot_w-1:0]  c_ot_one   = c_ot_w'(1);
    localparam logic [c_ot_w-1:0]  c_ot_div   = c_ot_w'(SCAN_DIV);
    localparam logic [c_ot_w-1:0]  c_ot_max   = c_ot_w'(SCAN_DIV - 1);
    localparam logic [DIGITS-1:0]  c_an_off   = {DIGITS{AN_OFF_LVL}};
    localparam logic [DIGITS-1:0]  c_an_one   = DIGITS'(1);

    // Scan position
    logic [c_cnt_w-1:0]  r_cnt,       w_cnt_d;
    logic [c_idx_w-1:0]  r_idx,       w_idx_d;

    // Staging copy of the display inputs, written by update
    scan_mode_t          r_stg_mode,  w_stg_mode_d;
    logic [8*DIGITS-1:0] r_stg_raw,   w_stg_raw_d;
    logic [4*DIGITS-1:0] r_stg_hex,   w_stg_hex_d;
    logic [DIGITS-1:0]   r_stg_dp,    w_stg_dp_d;
    logic [DIGITS-1:0]   r_stg_blank, w_stg_blank_d;
    logic                r_pending,   w_pending_d;

    // Active copy, only changes at a frame boundary
    scan_mode_t          r_act_mode,  w_act_mode_d;
    logic [8*DIGITS-1:0] r_act_raw,   w_act_raw_d;
    logic [4*DIGITS-1:0] r_act_hex,   w_act_hex_d;
    logic [DIGITS-1:0]   r_act_dp,    w_act_dp_d;
    logic [DIGITS-1:0]   r_act_blank, w_act_blank_d;

    // Output registers
    logic [DIGITS-1:0]   r_an,        w_an_d;
    logic [7:0]          r_cn,        w_cn_d;
    logic                r_frame_done, w_frame_done_d;

    logic                w_slot_end;
    logic                w_boundary;
    logic [7:0]          w_sel_raw;
    logic [3:0]          w_sel_nib;
    logic                w_sel_dp;
    logic                w_sel_blank;
    logic [7:0]          w_hex_cn;
    logic [c_ot_w-1:0]   w_on_time;
    logic [c_ot_w-1:0]   w_lit_hi;
    logic                w_lit;

    seg_hex_decode u_hex_decode (
        .i_nibble (w_sel_nib),
        .i_dp     (w_sel_dp),
        .o_cn     (w_hex_cn)
    );

    always_comb begin
        // Prescaler and digit index (scan runs DIGITS-1 down to 0)
        w_slot_end = (r_cnt == c_cnt_last);
        w_boundary = w_slot_end && (r_idx == '0);
        w_cnt_d    = w_slot_end ? '0 : r_cnt + c_cnt_one;
        w_idx_d    = r_idx;
        if (w_slot_end) begin
            w_idx_d = (r_idx == '0) ? c_idx_top : r_idx - c_idx_one;
        end

        // Staging: last update before a boundary wins
        w_stg_mode_d  = r_stg_mode;
        w_stg_raw_d   = r_stg_raw;
        w_stg_hex_d   = r_stg_hex;
        w_stg_dp_d    = r_stg_dp;
        w_stg_blank_d = r_stg_blank;
        w_pending_d   = r_pending;
        if (update) begin
            w_stg_mode_d  = scan_mode_t'(mode);
            w_stg_raw_d   = seg_raw;
            w_stg_hex_d   = hex_val;
            w_stg_dp_d    = dp;
            w_stg_blank_d = blank_mask;
            w_pending_d   = 1'b1;
        end

        // Commit at the frame boundary; an update landing on the boundary
        // itself bypasses staging so it is not delayed by a whole frame.
        w_act_mode_d  = r_act_mode;
        w_act_raw_d   = r_act_raw;
        w_act_hex_d   = r_act_hex;
        w_act_dp_d    = r_act_dp;
        w_act_blank_d = r_act_blank;
        if (w_boundary) begin
            if (update) begin
                w_act_mode_d  = scan_mode_t'(mode);
                w_act_raw_d   = seg_raw;
                w_act_hex_d   = hex_val;
                w_act_dp_d    = dp;
                w_act_blank_d = blank_mask;
            end else if (r_pending) begin
                w_act_mode_d  = r_stg_mode;
                w_act_raw_d   = r_stg_raw;
                w_act_hex_d   = r_stg_hex;
                w_act_dp_d    = r_stg_dp;
                w_act_blank_d = r_stg_blank;
            end
            w_pending_d = 1'b0;
        end

        // Per-digit fields of the digit currently being scanned
        w_sel_raw   = SEG_OFF;
        w_sel_nib   = '0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_sel_raw   = r_act_raw[8*i +: 8];
                w_sel_nib   = r_act_hex[4*i +: 4];
                w_sel_dp    = r_act_dp[i];
                w_sel_blank = r_act_blank[i];
            end
        end

        // PWM window: cnt==0 is always dark (anti-ghost dead time), and the
        // full-brightness window is clipped to the end of the slot.
        w_on_time = ((c_ot_w'(brightness) + c_ot_one) * c_ot_div) >> BRIGHT_W;
        w_lit_hi  = (w_on_time > c_ot_max) ? c_ot_max : w_on_time;
        w_lit     = (r_cnt != '0) && (c_ot_w'(r_cnt) <= w_lit_hi) && !w_sel_blank;

        w_an_d         = w_lit ? ~(c_an_one << r_idx) : c_an_off;
        w_cn_d         = (r_act_mode == MODE_HEX) ? w_hex_cn : w_sel_raw;
        w_frame_done_d = w_boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= c_idx_top;
            r_stg_mode   <= MODE_RAW;
            r_stg_raw    <= {DIGITS{SEG_OFF}};
            r_stg_hex    <= '0;
            r_stg_dp     <= '0;
            r_stg_blank  <= '1;
            r_pending    <= 1'b0;
            r_act_mode   <= MODE_RAW;
            r_act_raw    <= {DIGITS{SEG_OFF}};
            r_act_hex    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_an         <= c_an_off;
            r_cn         <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_d;
            r_idx        <= w_idx_d;
            r_stg_mode   <= w_stg_mode_d;
            r_stg_raw    <= w_stg_raw_d;
            r_stg_hex    <= w_stg_hex_d;
            r_stg_dp     <= w_stg_dp_d;
            r_stg_blank  <= w_stg_blank_d;
            r_pending    <= w_pending_d;
            r_act_mode   <= w_act_mode_d;
            r_act_raw    <= w_act_raw_d;
            r_act_hex    <= w_act_hex_d;
            r_act_dp     <= w_act_dp_d;
            r_act_blank  <= w_act_blank_d;
            r_an         <= w_an_d;
            r_cn         <= w_cn_d;
            r_frame_done <= w_frame_done_d;
        end
    end

    assign AN         = r_an;
    assign CN         = r_cn;
    assign frame_done = r_frame_done;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl. A SCAN_DIV=4
//               instance is checked cycle by cycle; a SCAN_DIV=16 instance
//               sharing the same inputs is used for the PWM duty checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        update;
    logic        mode;
    logic [63:0] seg_raw;
    logic [31:0] hex_val;
    logic [7:0]  dp;
    logic [7:0]  blank_mask;
    logic [2:0]  brightness;

    logic [7:0]  an, cn, an16, cn16;
    logic        fd, fd16;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4), .BRIGHT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .update     (update),
        .mode       (mode),
        .seg_raw    (seg_raw),
        .hex_val    (hex_val),
        .dp         (dp),
        .blank_mask (blank_mask),
        .brightness (brightness),
        .AN         (an),
        .CN         (cn),
        .frame_done (fd)
    );

    seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(16), .BRIGHT_W(3)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .update     (update),
        .mode       (mode),
        .seg_raw    (seg_raw),
        .hex_val    (hex_val),
        .dp         (dp),
        .blank_mask (blank_mask),
        .brightness (brightness),
        .AN         (an16),
        .CN         (cn16),
        .frame_done (fd16)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    // An update strobe only ever lasts for the edge that follows it.
    task automatic step();
        @(posedge clk);
        #1;
        update = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One digit slot of the SCAN_DIV=4 instance: dead cycle then 3 lit cycles.
    // upd_at >= 0 raises update after that sample (taken on the next edge).
    task automatic check_slot(input int d, input logic [7:0] exp_cn,
                              input logic [7:0] blank, input int upd_at);
        logic [7:0] exp_an;
        for (int j = 0; j < 4; j++) begin
            step();
            exp_an = 8'hFF;
            if (j != 0 && !blank[d]) exp_an = ~(8'h01 << d);
            chk($sformatf("slot%0d.%0d AN", d, j), an, exp_an);
            chk($sformatf("slot%0d.%0d CN", d, j), cn, exp_cn);
            chk($sformatf("slot%0d.%0d frame_done", d, j), fd, (d == 0 && j == 3));
            if (j == upd_at) update = 1'b1;
        end
    endtask

    task automatic check_frame(input logic [63:0] exp_cn, input logic [7:0] blank);
        for (int d = 7; d >= 0; d--) check_slot(d, exp_cn[8*d +: 8], blank, -1);
    endtask

    task automatic wait_frame();
        for (int k = 0; k < 200; k++) begin
            step();
            if (fd) break;
        end
        chk("wait_frame frame_done", fd, 1'b1);
    endtask

    // 32 cycles from reset release: dark throughout, boundary on the last.
    task automatic check_dark(input string tag);
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("%s AN k=%0d", tag, k), an, 8'hFF);
            chk($sformatf("%s frame_done k=%0d", tag, k), fd, (k == 32));
        end
    endtask

    task automatic count_lit16(input string tag, input int expv);
        int n;
        n = 0;
        for (int k = 0; k < 128; k++) begin
            step();
            if (an16 != 8'hFF) n++;
        end
        chk(tag, n, expv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        update     = 1'b0;
        mode       = 1'b0;
        seg_raw    = '0;
        hex_val    = '0;
        dp         = '0;
        blank_mask = '0;
        brightness = 3'd7;

        // Reset
        for (int k = 0; k < 3; k++) step();
        chk("reset AN", an, 8'hFF);
        chk("reset CN", cn, 8'hFF);
        chk("reset frame_done", fd, 1'b0);
        chk("reset AN16", an16, 8'hFF);
        chk("reset CN16", cn16, 8'hFF);
        chk("reset frame_done16", fd16, 1'b0);
        rst = 1'b0;
        check_dark("post-reset");

        // Raw scan
        mode       = 1'b0;
        seg_raw    = 64'h0123456789ABCDEF;
        blank_mask = 8'h00;
        update     = 1'b1;
        wait_frame();
        check_frame(64'h0123456789ABCDEF, 8'h00);

        // Hex mode with decimal points and one blanked digit
        mode       = 1'b1;
        hex_val    = 32'h80123ABF;
        dp         = 8'b1000_0001;
        blank_mask = 8'h20;
        update     = 1'b1;
        wait_frame();
        check_frame(64'h00C0F9A4B088830E, 8'h20);

        // Tear-free: two mid-frame updates, old frame unchanged, last wins
        for (int d = 7; d >= 5; d--) check_slot(d, 8'h00 + 64'h00C0F9A4B088830E >> (8*d), 8'h20, -1);
        mode       = 1'b0;
        seg_raw    = 64'h5555555555555555;
        blank_mask = 8'hFF;
        check_slot(4, 8'hA4, 8'h20, 1);
        check_slot(3, 8'hB0, 8'h20, -1);
        seg_raw    = 64'hFFEEDDCCBBAA9988;
        blank_mask = 8'h00;
        check_slot(2, 8'h88, 8'h20, 0);
        check_slot(1, 8'h83, 8'h20, -1);
        check_slot(0, 8'h0E, 8'h20, -1);
        check_frame(64'hFFEEDDCCBBAA9988, 8'h00);

        // Update coincident with the frame boundary commits directly
        mode    = 1'b1;
        hex_val = 32'h01234567;
        dp      = 8'h00;
        for (int d = 7; d >= 1; d--) check_slot(d, seg_raw[8*d +: 8], 8'h00, -1);
        check_slot(0, 8'h88, 8'h00, 2);
        check_frame(64'hC0F9A4B0999282F8, 8'h00);

        // Reset mid-frame in the idx=3 slot, with a simultaneous update
        check_slot(7, 8'hC0, 8'h00, -1);
        check_slot(6, 8'hF9, 8'h00, -1);
        check_slot(5, 8'hA4, 8'h00, -1);
        check_slot(4, 8'hB0, 8'h00, -1);
        step();
        chk("slot3 pre-reset dead AN", an, 8'hFF);
        chk("slot3 pre-reset dead CN", cn, 8'h99);
        step();
        chk("slot3 pre-reset lit AN", an, 8'hF7);
        chk("slot3 pre-reset lit CN", cn, 8'h99);
        mode       = 1'b0;
        seg_raw    = 64'h0;
        blank_mask = 8'h00;
        rst        = 1'b1;
        update     = 1'b1;
        step();
        chk("mid-reset AN", an, 8'hFF);
        chk("mid-reset CN", cn, 8'hFF);
        chk("mid-reset frame_done", fd, 1'b0);
        rst = 1'b0;
        check_dark("mid-reset frame1");
        check_dark("mid-reset frame2");

        // PWM duty on the SCAN_DIV=16 instance (8 slots per 128-cycle frame)
        mode       = 1'b0;
        seg_raw    = 64'h0123456789ABCDEF;
        blank_mask = 8'h00;
        brightness = 3'd7;
        update     = 1'b1;
        for (int k = 0; k < 300; k++) step();
        count_lit16("pwm bright=7 lit cycles", 120);
        brightness = 3'd0;
        step();
        step();
        count_lit16("pwm bright=0 lit cycles", 16);
        brightness = 3'd3;
        step();
        step();
        count_lit16("pwm bright=3 lit cycles", 64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
